// File: rtl/ssd_bcd_scan_driver_if.sv
// Host-side bundle for the seven-segment driver: value/load/blanking in; status and the
// scanned anode/segment lines out.
interface ssd_bcd_scan_driver_if #(
  parameter int VALUE_W  = 14,
  parameter int N_DIGITS = 4
);
  logic [VALUE_W-1:0]  value_in;
  logic                load;
  logic                blank_lz;
  logic                busy;
  logic                overflow;
  logic [N_DIGITS-1:0] anode;
  logic [6:0]          led_out;

  modport master (
    output value_in, load, blank_lz,
    input  busy, overflow, anode, led_out
  );

  modport slave (
    input  value_in, load, blank_lz,
    output busy, overflow, anode, led_out
  );
endinterface

// File: rtl/ssd_bcd_scan_driver.sv
// Double-dabble binary->BCD (one bit/cycle, busy VALUE_W+1 cycles, load while busy dropped)
// feeding a continuously scanned active-low display with blanking and overflow dashes.
module ssd_bcd_scan_driver #(
  parameter int VALUE_W     = 14,
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic                  clk,
  input logic                  rst,
  ssd_bcd_scan_driver_if.slave bus
);
  // ceil(VALUE_W*log10(2)) + 1 digits so the accumulator can never overflow
  localparam int N_BCD  = (VALUE_W * 30103 + 99999) / 100000 + 1;
  localparam int N_ACC  = (N_BCD > N_DIGITS) ? N_BCD : N_DIGITS;
  localparam int ACC_W  = 4 * N_ACC;
  localparam int ITER_W = $clog2(VALUE_W + 1);
  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [63:0] MAX_DISP = 64'(10**N_DIGITS - 1);
  localparam logic [6:0]  SEG_DASH = 7'b1111110;
  localparam logic [6:0]  SEG_OFF  = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_COMMIT
  } state_t;

  state_t                       state_q, state_d;
  logic [ITER_W-1:0]            iter_q;
  logic [VALUE_W-1:0]           bin_sr;
  logic [ACC_W-1:0]             bcd_acc, bcd_adj;
  logic                         ovf_pend, ovf_q;
  logic [N_DIGITS-1:0][3:0]     disp_q;
  logic [N_DIGITS-1:0]          lz_from;
  logic [CNT_W-1:0]             refresh_q;
  logic [IDX_W-1:0]             idx_q;
  logic [N_DIGITS-1:0]          anode_d, anode_q;
  logic [6:0]                   led_d, led_q;
  logic                         blank;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b0000001;
      4'd1:    seg_encode = 7'b1001111;
      4'd2:    seg_encode = 7'b0010010;
      4'd3:    seg_encode = 7'b0000110;
      4'd4:    seg_encode = 7'b1001100;
      4'd5:    seg_encode = 7'b0100100;
      4'd6:    seg_encode = 7'b0100000;
      4'd7:    seg_encode = 7'b0001111;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0000100;
      default: seg_encode = SEG_OFF;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.load) state_d = S_CONVERT;
      S_CONVERT: if (iter_q == ITER_W'(1)) state_d = S_COMMIT;
      S_COMMIT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_acc;
    for (int k = 0; k < N_ACC; k++) begin
      if (bcd_acc[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_acc[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_q   <= '0;
      bin_sr   <= '0;
      bcd_acc  <= '0;
      ovf_pend <= 1'b0;
      ovf_q    <= 1'b0;
      disp_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.load) begin
            bin_sr   <= bus.value_in;
            bcd_acc  <= '0;
            iter_q   <= ITER_W'(VALUE_W);
            ovf_pend <= (64'(bus.value_in) > MAX_DISP);
          end
        end
        S_CONVERT: begin
          bcd_acc <= {bcd_adj[ACC_W-2:0], bin_sr[VALUE_W-1]};
          bin_sr  <= bin_sr << 1;
          iter_q  <= iter_q - ITER_W'(1);
        end
        S_COMMIT: begin
          // display only changes here, so the scan never shows a half-converted value
          for (int i = 0; i < N_DIGITS; i++) disp_q[i] <= bcd_acc[4*i +: 4];
          ovf_q <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  // lz_from[i]: digits i..N_DIGITS-1 are all zero
  always_comb begin
    lz_from = '0;
    lz_from[N_DIGITS-1] = (disp_q[N_DIGITS-1] == 4'd0);
    for (int i = N_DIGITS - 2; i >= 0; i--) begin
      lz_from[i] = (disp_q[i] == 4'd0) && lz_from[i+1];
    end
  end

  always_comb begin
    blank   = bus.blank_lz && !ovf_q && (idx_q != '0) && lz_from[idx_q];
    anode_d = '1;
    led_d   = SEG_OFF;
    if (!blank) begin
      anode_d[idx_q] = 1'b0;
      led_d          = ovf_q ? SEG_DASH : seg_encode(disp_q[idx_q]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_q <= '0;
      idx_q     <= '0;
      anode_q   <= '1;
      led_q     <= SEG_OFF;
    end else begin
      if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_q <= '0;
        idx_q     <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        refresh_q <= refresh_q + CNT_W'(1);
      end
      anode_q <= anode_d;
      led_q   <= led_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.overflow = ovf_q;
  assign bus.anode    = anode_q;
  assign bus.led_out  = led_q;
endmodule
